renkon_mem_feat_pp: RTL and testbench

Parametrised ping-pong (double-buffered) feature memory for the renkon core. It holds two banks of 2**FACCUM words each. The load side (DMA/ninjin) fills one bank while the compute side reads, and optionally writes back, the other bank. A two-flag handshake swaps the banks, so loading and convolution overlap without any address collision.

---
 rtl/renkon_mem_feat_pp_pkg.sv | 15 +
 rtl/renkon_mem_feat_pp_if.sv | 39 +++
 rtl/renkon_mem_feat_bank.sv | 35 +++
 rtl/renkon_mem_feat_pp.sv | 127 ++++++++++++
 tb/tb_renkon_mem_feat_pp.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/renkon_mem_feat_pp_pkg.sv
// Shared widths, read-latency choices and bank-index type for the ping-pong feature memory.
package renkon_mem_feat_pp_pkg;

  localparam int unsigned DWIDTH_DEF = 16;
  localparam int unsigned FACCUM_DEF = 10;
  localparam int unsigned BANK_W     = 1;

  typedef enum int unsigned {
    RD_LAT_ADDR = 1,
    RD_LAT_OREG = 2
  } rd_lat_e;

  typedef logic [BANK_W-1:0] bank_t;

endpackage

// File: rtl/renkon_mem_feat_pp_if.sv
// Load-side, compute-side and status signals of the ping-pong feature memory.
interface renkon_mem_feat_pp_if
  import renkon_mem_feat_pp_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned FACCUM = FACCUM_DEF
);

  logic                     flush;
  logic                     we_a;
  logic [FACCUM-1:0]        addr_a;
  logic signed [DWIDTH-1:0] wdata_a;
  logic                     fill_done;
  logic                     fill_ready;
  logic                     re_b;
  logic                     we_b;
  logic [FACCUM-1:0]        addr_b;
  logic signed [DWIDTH-1:0] wdata_b;
  logic signed [DWIDTH-1:0] rdata_b;
  logic                     rvalid_b;
  logic                     read_done;
  logic                     read_ready;
  bank_t                    fill_sel;
  bank_t                    read_sel;
  logic                     err;

  modport master (
    output flush, we_a, addr_a, wdata_a, fill_done,
    output re_b, we_b, addr_b, wdata_b, read_done,
    input  fill_ready, rdata_b, rvalid_b, read_ready, fill_sel, read_sel, err
  );

  modport slave (
    input  flush, we_a, addr_a, wdata_a, fill_done,
    input  re_b, we_b, addr_b, wdata_b, read_done,
    output fill_ready, rdata_b, rvalid_b, read_ready, fill_sel, read_sel, err
  );

endinterface

// File: rtl/renkon_mem_feat_bank.sv
// One feature bank: load-side write port, compute-side read/write port, read-first sync read.
module renkon_mem_feat_bank
  import renkon_mem_feat_pp_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned FACCUM = FACCUM_DEF
) (
  input  logic                     clk,
  input  logic                     we_a,
  input  logic [FACCUM-1:0]        addr_a,
  input  logic signed [DWIDTH-1:0] wdata_a,
  input  logic                     re_b,
  input  logic                     we_b,
  input  logic [FACCUM-1:0]        addr_b,
  input  logic signed [DWIDTH-1:0] wdata_b,
  output logic signed [DWIDTH-1:0] rdata_b
);

  localparam int unsigned WORDS = 2 ** FACCUM;

  logic signed [DWIDTH-1:0] mem [WORDS];

  // Ports A and B never write the same bank in one cycle, so one write port suffices.
  always_ff @(posedge clk) begin
    if (we_a) begin
      mem[addr_a] <= wdata_a;
    end else if (we_b) begin
      mem[addr_b] <= wdata_b;
    end
    if (re_b) begin
      rdata_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/renkon_mem_feat_pp.sv
// Double-buffered feature memory: fill one bank while compute reads/writes back the other.
module renkon_mem_feat_pp
  import renkon_mem_feat_pp_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned FACCUM = FACCUM_DEF,
  parameter int unsigned RD_LAT = RD_LAT_ADDR
) (
  input logic                 clk,
  input logic                 rst,
  renkon_mem_feat_pp_if.slave bus
);

  logic [1:0]               full, full_n;
  bank_t                    fill_sel_q, fill_sel_n;
  bank_t                    read_sel_q, read_sel_n;
  logic                     err_q, err_n;
  logic                     fill_ready, read_ready, issue;
  logic                     rvalid_1;
  bank_t                    rsel_1;
  logic signed [DWIDTH-1:0] bank_rdata [2];
  logic signed [DWIDTH-1:0] data_1;

  assign fill_ready = !full[fill_sel_q];
  assign read_ready = full[read_sel_q];
  assign issue      = bus.re_b && read_ready;

  for (genvar k = 0; k < 2; k++) begin : g_bank
    renkon_mem_feat_bank #(
      .DWIDTH (DWIDTH),
      .FACCUM (FACCUM)
    ) u_bank (
      .clk     (clk),
      .we_a    (bus.we_a && fill_ready && (fill_sel_q == bank_t'(k))),
      .addr_a  (bus.addr_a),
      .wdata_a (bus.wdata_a),
      .re_b    (issue && (read_sel_q == bank_t'(k))),
      .we_b    (bus.we_b && read_ready && (read_sel_q == bank_t'(k))),
      .addr_b  (bus.addr_b),
      .wdata_b (bus.wdata_b),
      .rdata_b (bank_rdata[k])
    );
  end

  // Fill and read pointers only both advance when they name different banks,
  // so the two full-bit updates never collide.
  always_comb begin
    full_n     = full;
    fill_sel_n = fill_sel_q;
    read_sel_n = read_sel_q;
    if (bus.fill_done && fill_ready) begin
      full_n[fill_sel_q] = 1'b1;
      fill_sel_n         = ~fill_sel_q;
    end
    if (bus.read_done && read_ready) begin
      full_n[read_sel_q] = 1'b0;
      read_sel_n         = ~read_sel_q;
    end
    err_n = err_q
          | (bus.we_a      && !fill_ready)
          | (bus.fill_done && !fill_ready)
          | (bus.re_b      && !read_ready)
          | (bus.read_done && !read_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full       <= '0;
      fill_sel_q <= '0;
      read_sel_q <= '0;
      err_q      <= 1'b0;
    end else if (bus.flush) begin
      full       <= '0;
      fill_sel_q <= '0;
      read_sel_q <= '0;
      err_q      <= 1'b0;
    end else begin
      full       <= full_n;
      fill_sel_q <= fill_sel_n;
      read_sel_q <= read_sel_n;
      err_q      <= err_n;
    end
  end

  // Bank index travels with the read so a read_done cannot redirect an in-flight result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_1 <= 1'b0;
      rsel_1   <= '0;
    end else begin
      rvalid_1 <= issue;
      if (issue) begin
        rsel_1 <= read_sel_q;
      end
    end
  end

  assign data_1 = bank_rdata[rsel_1];

  if (RD_LAT == RD_LAT_OREG) begin : g_oreg
    logic                     rvalid_2;
    logic signed [DWIDTH-1:0] data_2;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rvalid_2 <= 1'b0;
        data_2   <= '0;
      end else begin
        rvalid_2 <= rvalid_1;
        if (rvalid_1) begin
          data_2 <= data_1;
        end
      end
    end
    assign bus.rdata_b  = data_2;
    assign bus.rvalid_b = rvalid_2;
  end else begin : g_noreg
    assign bus.rdata_b  = data_1;
    assign bus.rvalid_b = rvalid_1;
  end

  assign bus.fill_ready = fill_ready;
  assign bus.read_ready = read_ready;
  assign bus.fill_sel   = fill_sel_q;
  assign bus.read_sel   = read_sel_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_renkon_mem_feat_pp.sv
// Bench for the ping-pong feature memory: RD_LAT=1 and RD_LAT=2 instances driven in lockstep.
module tb_renkon_mem_feat_pp;
  import renkon_mem_feat_pp_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned FA    = 4;
  localparam int unsigned WORDS = 2 ** FA;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 flush = 1'b0, we_a = 1'b0, fill_done = 1'b0;
  logic                 re_b = 1'b0, we_b = 1'b0, read_done = 1'b0;
  logic [FA-1:0]        addr_a = '0, addr_b = '0;
  logic signed [DW-1:0] wdata_a = '0, wdata_b = '0;

  renkon_mem_feat_pp_if #(.DWIDTH(DW), .FACCUM(FA)) b1 ();
  renkon_mem_feat_pp_if #(.DWIDTH(DW), .FACCUM(FA)) b2 ();

  assign b1.flush = flush;       assign b2.flush = flush;
  assign b1.we_a = we_a;         assign b2.we_a = we_a;
  assign b1.addr_a = addr_a;     assign b2.addr_a = addr_a;
  assign b1.wdata_a = wdata_a;   assign b2.wdata_a = wdata_a;
  assign b1.fill_done = fill_done; assign b2.fill_done = fill_done;
  assign b1.re_b = re_b;         assign b2.re_b = re_b;
  assign b1.we_b = we_b;         assign b2.we_b = we_b;
  assign b1.addr_b = addr_b;     assign b2.addr_b = addr_b;
  assign b1.wdata_b = wdata_b;   assign b2.wdata_b = wdata_b;
  assign b1.read_done = read_done; assign b2.read_done = read_done;

  renkon_mem_feat_pp #(.DWIDTH(DW), .FACCUM(FA), .RD_LAT(1)) u_lat1 (.clk(clk), .rst(rst), .bus(b1.slave));
  renkon_mem_feat_pp #(.DWIDTH(DW), .FACCUM(FA), .RD_LAT(2)) u_lat2 (.clk(clk), .rst(rst), .bus(b2.slave));

  // Reference model: two arrays of words, two full flags, two pointers, sticky error
  logic signed [DW-1:0] mem_m [2][WORDS];
  bit                   known_m [2][WORDS];
  bit                   full_m [2];
  bit                   fsel_m, rsel_m, err_m;

  typedef struct {
    int                   due;
    logic signed [DW-1:0] d;
    bit                   known;
  } pend_t;
  pend_t q1[$], q2[$];

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    bit fl, wa; int aa, da; bit fd, rb, wb; int ab, db; bit rd;
    logic [4:0] st; bit rv; int rdv;
  } vec_t;
  vec_t tbl [25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] st1();
    return {b1.fill_ready, b1.read_ready, b1.fill_sel, b1.read_sel, b1.err};
  endfunction
  function automatic logic [4:0] st2();
    return {b2.fill_ready, b2.read_ready, b2.fill_sel, b2.read_sel, b2.err};
  endfunction

  task automatic check_all();
    logic [4:0] exp_st;
    bit         ev;
    exp_st = {!full_m[fsel_m], full_m[rsel_m], fsel_m, rsel_m, err_m};
    chk("model_status_lat1", st1(), exp_st);
    chk("model_status_lat2", st2(), exp_st);
    ev = (q1.size() > 0) && (q1[0].due == cyc);
    chk("model_rvalid_lat1", b1.rvalid_b, ev);
    if (ev) begin
      if (q1[0].known) chk("model_rdata_lat1", b1.rdata_b, q1[0].d);
      void'(q1.pop_front());
    end
    ev = (q2.size() > 0) && (q2[0].due == cyc);
    chk("model_rvalid_lat2", b2.rvalid_b, ev);
    if (ev) begin
      if (q2[0].known) chk("model_rdata_lat2", b2.rdata_b, q2[0].d);
      void'(q2.pop_front());
    end
  endtask

  // Applies the current inputs to the model, advances one clock, then compares.
  task automatic step();
    bit fr, rr, f0, r0;
    fr = !full_m[fsel_m];
    rr = full_m[rsel_m];
    f0 = fsel_m;
    r0 = rsel_m;
    if (re_b && rr) begin
      q1.push_back('{due: cyc + 1, d: mem_m[r0][addr_b], known: known_m[r0][addr_b]});
      q2.push_back('{due: cyc + 2, d: mem_m[r0][addr_b], known: known_m[r0][addr_b]});
    end
    if (we_a && fr) begin
      mem_m[f0][addr_a] = wdata_a;
      known_m[f0][addr_a] = 1'b1;
    end
    if (we_b && rr) begin
      mem_m[r0][addr_b] = wdata_b;
      known_m[r0][addr_b] = 1'b1;
    end
    if (flush) begin
      full_m = '{0, 0};
      fsel_m = 0;
      rsel_m = 0;
      err_m  = 0;
    end else begin
      if ((we_a || fill_done) && !fr) err_m = 1;
      if ((re_b || read_done) && !rr) err_m = 1;
      if (fill_done && fr) begin
        full_m[f0] = 1;
        fsel_m = !f0;
      end
      if (read_done && rr) begin
        full_m[r0] = 0;
        rsel_m = !r0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic idle();
    flush = 0; we_a = 0; fill_done = 0; re_b = 0; we_b = 0; read_done = 0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    #1;
    full_m = '{0, 0};
    fsel_m = 0;
    rsel_m = 0;
    err_m  = 0;
    q1.delete();
    q2.delete();
    check_all();
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    tbl = '{
      '{0,1,0,10,  0,0,0,0,0,  0, 5'b10000, 0, 0},
      '{0,1,1,20,  0,0,0,0,0,  0, 5'b10000, 0, 0},
      '{0,1,2,30,  0,0,0,0,0,  0, 5'b10000, 0, 0},
      '{0,1,3,40,  0,0,0,0,0,  0, 5'b10000, 0, 0},
      '{0,0,0,0,   1,0,0,0,0,  0, 5'b11100, 0, 0},
      '{0,1,2,-5,  0,1,0,2,0,  0, 5'b11100, 1, 30},
      '{0,0,0,0,   1,0,0,0,0,  0, 5'b01000, 0, 0},
      '{0,0,0,0,   0,0,0,0,0,  1, 5'b11010, 0, 0},
      '{0,0,0,0,   0,1,0,2,0,  0, 5'b11010, 1, -5},
      '{0,1,5,77,  0,0,0,0,0,  0, 5'b11010, 0, 0},
      '{0,0,0,0,   1,0,0,0,0,  0, 5'b01110, 0, 0},
      '{0,1,2,999, 0,0,0,0,0,  0, 5'b01111, 0, 0},
      '{0,0,0,0,   1,0,0,0,0,  0, 5'b01111, 0, 0},
      '{0,0,0,0,   0,1,0,2,0,  0, 5'b01111, 1, -5},
      '{0,0,0,0,   0,0,0,0,0,  1, 5'b11101, 0, 0},
      '{0,0,0,0,   1,0,0,0,0,  1, 5'b11011, 0, 0},
      '{0,0,0,0,   0,0,1,7,100,0, 5'b11011, 0, 0},
      '{0,0,0,0,   0,1,0,7,0,  0, 5'b11011, 1, 100},
      '{0,0,0,0,   0,0,1,7,101,0, 5'b11011, 0, 0},
      '{0,0,0,0,   0,1,0,7,0,  0, 5'b11011, 1, 101},
      '{0,0,0,0,   0,1,1,7,55, 0, 5'b11011, 1, 101},
      '{0,0,0,0,   0,1,0,7,0,  0, 5'b11011, 1, 55},
      '{1,0,0,0,   0,0,0,0,0,  0, 5'b10000, 0, 0},
      '{0,0,0,0,   1,0,0,0,0,  0, 5'b11100, 0, 0},
      '{0,0,0,0,   0,1,0,0,0,  0, 5'b11100, 1, 10}
    };
    full_m = '{0, 0};
    fsel_m = 0; rsel_m = 0; err_m = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_status_lat1", st1(), 5'b10000);
    chk("reset_status_lat2", st2(), 5'b10000);
    chk("reset_rvalid_lat1", b1.rvalid_b, 0);
    chk("reset_rvalid_lat2", b2.rvalid_b, 0);
    chk("reset_rdata_lat2", b2.rdata_b, 0);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      flush = tbl[i].fl; we_a = tbl[i].wa; fill_done = tbl[i].fd;
      re_b = tbl[i].rb; we_b = tbl[i].wb; read_done = tbl[i].rd;
      addr_a = FA'(tbl[i].aa); wdata_a = DW'(tbl[i].da);
      addr_b = FA'(tbl[i].ab); wdata_b = DW'(tbl[i].db);
      step();
      chk($sformatf("vec%0d_status_lat1", i), st1(), tbl[i].st);
      chk($sformatf("vec%0d_status_lat2", i), st2(), tbl[i].st);
      chk($sformatf("vec%0d_rvalid_lat1", i), b1.rvalid_b, tbl[i].rv);
      if (tbl[i].rv) chk($sformatf("vec%0d_rdata_lat1", i), b1.rdata_b, tbl[i].rdv);
    end
    idle();
    step();
    chk("lat2_second_cycle_rvalid", b2.rvalid_b, 1);
    chk("lat2_second_cycle_rdata", b2.rdata_b, 10);

    // Reset with a RD_LAT=2 read in flight
    re_b = 1; addr_b = 0;
    step();
    chk("inflight_rdata_lat1", b1.rdata_b, 10);
    idle();
    do_rst();
    chk("rst_kills_rvalid_lat2", b2.rvalid_b, 0);
    step();
    chk("rst_no_late_rvalid_lat2", b2.rvalid_b, 0);
    chk("rst_status", st1(), 5'b10000);
    fill_done = 1;
    step();
    idle();
    re_b = 1; addr_b = 0;
    step();
    chk("retained_rdata_lat1", b1.rdata_b, 10);
    idle();
    read_done = 1;
    step();
    idle();
    re_b = 1;
    step();
    chk("err_after_bad_read", b1.err, 1);
    chk("no_rvalid_bad_read", b1.rvalid_b, 0);
    idle();
    flush = 1;
    step();
    chk("flush_clears_err", b1.err, 0);
    idle();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        idle();
        do_rst();
      end
      flush     = ($urandom_range(0, 199) == 0);
      we_a      = $urandom_range(0, 1);
      fill_done = ($urandom_range(0, 7) == 0);
      re_b      = $urandom_range(0, 1);
      we_b      = ($urandom_range(0, 3) == 0);
      read_done = ($urandom_range(0, 7) == 0);
      addr_a    = FA'($urandom);
      addr_b    = FA'($urandom);
      wdata_a   = DW'($urandom);
      wdata_b   = DW'($urandom);
      step();
    end
    idle();
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
